// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x4 keypad row scan, debounce and key decode with one-cycle valid strobe.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat strobes while a key stays held.
module keypad_matrix_scanner #(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] matricial_col,
  output logic [3:0] matricial_lin,
  output logic [3:0] key_code,
  output logic       key_valid
);
  localparam int TICK_DIV  = CLK_FREQ_HZ / SCAN_HZ;
  localparam int DB_TICKS  = DEBOUNCE_MS * SCAN_HZ / 1000;
  localparam int REP_DELAY = REPEAT_DELAY_MS * SCAN_HZ / 1000;
  localparam int REP_RATE  = REPEAT_RATE_MS * SCAN_HZ / 1000;
  localparam int DW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DB_TICKS + 1);
  // indexed by {row, col}; * -> E, # -> F
  localparam logic [15:0][3:0] KEYMAP = {4'hD, 4'hF, 4'h0, 4'hE, 4'hC, 4'h9, 4'h8, 4'h7,
                                         4'hB, 4'h6, 4'h5, 4'h4, 4'hA, 4'h3, 4'h2, 4'h1};
  if (TICK_DIV < 2 || DB_TICKS < 1 || REP_DELAY < 1 || REP_RATE < 1) begin : g_bad_cfg
    $error("keypad_matrix_scanner: invalid timing parameters");
  end
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div;
  logic [3:0] col_m, col_s, code_nx;
  logic [1:0] row, row_nx, kcol, kcol_nx, hit_col;
  logic [CW-1:0] cnt, cnt_nx;
  logic tick, hit, idle, same, valid_nx, rep;
  assign tick = div == DW'(TICK_DIV - 1);
  assign idle = &col_s;
  assign hit = col_s == 4'b1110 || col_s == 4'b1101 || col_s == 4'b1011 || col_s == 4'b0111;
  assign hit_col = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
  assign same = hit && hit_col == kcol;
  assign matricial_lin = ~(4'b0001 << row);
  always_comb begin
    state_nx = state;
    row_nx = row;
    kcol_nx = kcol;
    cnt_nx = cnt;
    code_nx = key_code;
    valid_nx = 1'b0;
    if (tick)
      case (state)
        SCAN:
          if (hit) begin
            state_nx = DEBOUNCE;
            kcol_nx = hit_col;
            cnt_nx = CW'(DB_TICKS);
          end else
            row_nx = row + 2'd1;
        DEBOUNCE:
          if (!same) begin
            state_nx = SCAN;
            row_nx = row + 2'd1;
          end else if (cnt == CW'(1)) begin
            state_nx = HOLD;
            code_nx = KEYMAP[{row, kcol}];
            valid_nx = 1'b1;
          end else
            cnt_nx = cnt - 1'b1;
        HOLD:
          if (idle) begin
            state_nx = RELEASE;
            cnt_nx = CW'(DB_TICKS);
          end
        RELEASE:
          if (!idle)
            state_nx = HOLD;
          else if (cnt == CW'(1)) begin
            state_nx = SCAN;
            row_nx = row + 2'd1;
          end else
            cnt_nx = cnt - 1'b1;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      div <= '0;
      state <= SCAN;
      row <= 2'd0;
      kcol <= 2'd0;
      cnt <= '0;
      key_code <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      col_m <= matricial_col;
      col_s <= col_m;
      div <= tick ? '0 : div + 1'b1;
      state <= state_nx;
      row <= row_nx;
      kcol <= kcol_nx;
      cnt <= cnt_nx;
      key_code <= code_nx;
      key_valid <= valid_nx | rep;
    end
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2((REP_DELAY > REP_RATE ? REP_DELAY : REP_RATE) + 1);
  logic [RW-1:0] rcnt;
  logic held;
  assign held = tick && state == HOLD && !idle;
  assign rep = held && rcnt == RW'(1);
  // every entry into HOLD restarts the first-repeat delay
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      rcnt <= '0;
    else
      rcnt <= (state_nx == HOLD && state != HOLD) ? RW'(REP_DELAY) :
              !held ? rcnt : rep ? RW'(REP_RATE) : rcnt - 1'b1;
`else
  assign rep = 1'b0;
`endif
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: keypad model driving columns from rows, strobe scoreboard, timing checks.
module tb_keypad_matrix_scanner;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] matricial_col, matricial_lin, key_code, exp_code;
  logic key_valid;
  logic [15:0] pressed = '0;
  logic [3:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int nstrobe = 0;
  typedef struct {
    int key;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[8];

  keypad_matrix_scanner #(
    .CLK_FREQ_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_MS(30),
    .REPEAT_DELAY_MS(100), .REPEAT_RATE_MS(50)
  ) dut (
    .clk(clk), .rst(rst), .matricial_col(matricial_col),
    .matricial_lin(matricial_lin), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // a pressed key shorts its column low only while its row is driven low
  always_comb begin
    matricial_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !matricial_lin[r]) matricial_col[c] = 1'b0;
  end

  always @(negedge clk)
    if (rst && key_valid) begin
      nstrobe++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL strobe: key_valid with code %h, no strobe required", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code) begin
          mismatched++;
          $display("FAIL strobe_code: got %h required %h", key_code, exp_code);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rowlin(input int r);
    return r == 0 ? 4'b1110 : r == 1 ? 4'b1101 : r == 2 ? 4'b1011 : 4'b0111;
  endfunction

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic wait_lin(input logic [3:0] l);
    int n = 0;
    while (matricial_lin !== l && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (matricial_lin !== l) begin
      compared++;
      mismatched++;
      $display("FAIL wait_lin: lin %b required %b", matricial_lin, l);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!key_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_change(input logic [3:0] l, output int lat);
    lat = 0;
    while (matricial_lin === l && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic press_key(input int k, input logic [3:0] code);
    int r = k / 4;
    int lat;
    int frozen = 1;
    wait_lin(rowlin((r + 3) % 4));
    pressed = 16'b1 << k;
    exp_q.push_back(code);
    wait_lin(rowlin(r));
    wait_valid(lat);
    check($sformatf("latency_key%0d", k), lat, 40);
    repeat (60) begin
      @(negedge clk);
      if (matricial_lin !== rowlin(r)) frozen = 0;
    end
    check($sformatf("frozen_key%0d", k), frozen, 1);
    pressed = '0;
    wait_change(rowlin(r), lat);
    check($sformatf("release_delay_key%0d", k), lat, 40);
    check($sformatf("next_row_key%0d", k), matricial_lin, rowlin((r + 1) % 4));
  endtask

  initial begin
    int lat, n0, chg;
    logic [3:0] prev;
    vecs = '{'{5, 4'h5}, '{0, 4'h1}, '{3, 4'hA}, '{8, 4'h7},
             '{11, 4'hC}, '{13, 4'h0}, '{12, 4'hE}, '{15, 4'hD}};
    repeat (3) @(negedge clk);
    check("reset_lin", matricial_lin, 4'b1110);
    check("reset_valid", key_valid, 0);
    check("reset_code", key_code, 0);
    rst = 1'b1;
    prev = matricial_lin;
    for (int i = 0; i < 4; i++) begin
      wait_change(prev, lat);
      check($sformatf("rotate_period%0d", i), lat, 10);
      check($sformatf("rotate_lin%0d", i), matricial_lin, rowlin((i + 1) % 4));
      prev = matricial_lin;
    end
    for (int i = 0; i < 8; i++) press_key(vecs[i].key, vecs[i].code);
    // "#" bounces: low 2 ticks, high 1 tick, then steady low
    n0 = nstrobe;
    wait_lin(rowlin(2));
    wait_lin(rowlin(3));
    pressed = 16'h4000;
    repeat (20) @(negedge clk);
    pressed = '0;
    repeat (10) @(negedge clk);
    pressed = 16'h4000;
    exp_q.push_back(4'hF);
    wait_valid(lat);
    check("bounce_latency", lat, 70);
    repeat (10) @(negedge clk);
    pressed = '0;
    wait_change(rowlin(3), lat);
    check("bounce_strobes", nstrobe - n0, 1);
    // two columns low in row 0 never qualifies
    n0 = nstrobe;
    wait_lin(rowlin(2));
    wait_lin(rowlin(3));
    pressed = 16'h0009;
    chg = 0;
    prev = matricial_lin;
    repeat (80) begin
      @(negedge clk);
      if (matricial_lin !== prev) chg++;
      prev = matricial_lin;
    end
    pressed = '0;
    check("multi_row_steps", chg, 8);
    check("multi_strobes", nstrobe - n0, 0);
    // "*" with a one-tick bounce during release
    n0 = nstrobe;
    wait_lin(rowlin(2));
    pressed = 16'h1000;
    exp_q.push_back(4'hE);
    wait_lin(rowlin(3));
    wait_valid(lat);
    check("glitch_latency", lat, 40);
    repeat (10) @(negedge clk);
    pressed = '0;
    repeat (10) @(negedge clk);
    pressed = 16'h1000;
    repeat (10) @(negedge clk);
    pressed = '0;
    wait_change(rowlin(3), lat);
    check("glitch_release_delay", lat, 40);
    check("glitch_next_row", matricial_lin, 4'b1110);
    check("glitch_strobes", nstrobe - n0, 1);
    // asynchronous reset in the middle of a debounce
    wait_lin(rowlin(1));
    pressed = 16'h0400;
    wait_lin(rowlin(2));
    repeat (25) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_lin", matricial_lin, 4'b1110);
    check("midreset_valid", key_valid, 0);
    check("midreset_code", key_code, 0);
    repeat (3) @(negedge clk);
    pressed = '0;
    rst = 1'b1;
    n0 = nstrobe;
    repeat (60) @(negedge clk);
    check("midreset_strobes", nstrobe - n0, 0);
`ifdef KEYPAD_AUTOREPEAT_EN
    begin
      int times[5] = '{0, 0, 0, 0, 0};
      int req[5] = '{40, 140, 190, 240, 290};
      int k = 0;
      int c = 0;
      wait_lin(rowlin(2));
      pressed = 16'h8000;
      repeat (5) exp_q.push_back(4'hD);
      wait_lin(rowlin(3));
      while (c < 300) begin
        @(negedge clk);
        c++;
        if (key_valid && k < 5) begin
          times[k] = c;
          k++;
        end
      end
      pressed = '0;
      check("repeat_count", k, 5);
      for (int i = 0; i < 5; i++) check($sformatf("repeat_time%0d", i), times[i], req[i]);
      wait_change(rowlin(3), lat);
    end
`endif
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Drives the rows of the 4x4 matrix keypad on GPIO_0 and reads its columns.
- Debounces a single key press and decodes it to a 4-bit key code with a one-cycle valid strobe.
- Output is the keyCode/keyCodeValid pair that the lock controller consumes for PIN entry and setup.
- Runs on the 50 MHz board clock; scanning is paced by an internal 1 kHz scan tick.

Parameters:
- CLK_FREQ_HZ, 50000000, input clock frequency.
- SCAN_HZ, 1000, scan tick rate. TICK_DIV = CLK_FREQ_HZ/SCAN_HZ, must be >= 2.
- DEBOUNCE_MS, 20, stable time required for press and for release. DB_TICKS = DEBOUNCE_MS*SCAN_HZ/1000, must be >= 1.
- REPEAT_DELAY_MS, 500, first auto-repeat delay (optional feature only).
- REPEAT_RATE_MS, 200, auto-repeat period (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- matricial_col  in  4  keypad columns, active-low (board pull-ups); bit0 = column 0.
- matricial_lin  out  4  keypad rows, one-hot low; bit0 = row 0.
- key_code  out  4  decoded key, held stable until the next valid.
- key_valid  out  1  single-cycle strobe, key_code valid in the same cycle.

Behaviour:
- Reset (rst=0, asynchronous): matricial_lin=4'b1110, key_code=4'h0, key_valid=0, state=SCAN, row pointer=0, tick divider=0, sync flops=4'b1111.
- matricial_col passes through a 2-flop synchronizer. All decisions use the synchronized value, sampled only in a tick cycle.
- Tick: one-cycle pulse, every TICK_DIV clocks; the divider free-runs in every state.
- Key map, row-major. Row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = *,0,#,D.
- Codes: digits 0-9 -> 4'h0-4'h9; A-D -> 4'hA-4'hD; * -> 4'hE; # -> 4'hF.
- Column pattern classes: "Hit" = exactly one column low. "Idle" = all columns high. "Multi" = two or more columns low, treated as Idle in SCAN and as a mismatch in DEBOUNCE.
- SCAN:
  - On tick with Hit: latch row and column, load counter = DB_TICKS, row stays frozen, go to DEBOUNCE.
  - On tick otherwise: row pointer advances 0->1->2->3->0; matricial_lin updates in the same cycle.
- DEBOUNCE:
  - On tick, same single column low: decrement counter.
  - On tick, anything else: go to SCAN and advance the row.
  - When the counter reaches 0: key_code <= decoded key and key_valid=1 for exactly one clock (the next cycle); go to HOLD.
- HOLD (row frozen):
  - On tick with Idle: load counter = DB_TICKS, go to RELEASE.
  - Otherwise: stay in HOLD. No further key_valid unless the optional feature is enabled.
- RELEASE:
  - On tick with Idle: decrement counter.
  - On tick with any column low: go to HOLD.
  - When the counter reaches 0: go to SCAN and advance the row.
- Latency: key_valid asserts DB_TICKS ticks (+0..1 clk) after the first tick that saw the Hit. Nominal 20 ms.
- Exactly one key_valid per physical press; a second key pressed while holding the first is ignored.
- Bounce shorter than DB_TICKS on release never produces a second strobe.
- Reset mid-operation returns to the reset values immediately; no strobe is emitted.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - HOLD counts ticks. The first repeat strobe (same key_code) comes at REPEAT_DELAY_MS*SCAN_HZ/1000 ticks after the initial strobe.
  - Further strobes follow every REPEAT_RATE_MS*SCAN_HZ/1000 ticks while the key stays held.
  - The counter is reset whenever HOLD is entered from RELEASE.
- Undefined: no repeat logic is synthesized; HOLD emits nothing.

Test Plan (all tests use CLK_FREQ_HZ=1000, SCAN_HZ=100, DEBOUNCE_MS=30 -> tick every 10 clk, DB_TICKS=3):
1. Reset with rst low, columns 4'b1111. Expect matricial_lin=4'b1110, key_valid=0, key_code=0. Release reset: lin rotates 1110->1101->1011->0111->1110, one step per 10 clk.
2. Model key "5": pull col1 low only while lin=4'b1101, held 100 clk. Expect exactly one key_valid with key_code=4'h5, 3 ticks after detection. lin stays frozen at 1101 until 3 idle ticks after release.
3. Bounce: key "#" (row3/col2) low for 2 ticks, high 1 tick, then low steady. Expect no strobe until 3 consecutive matching ticks, then one strobe with key_code=4'hF.
4. Multi-press: while lin=4'b1110, col0 and col3 low together. Expect no key_valid and continued scanning.
5. Release glitch: after "*" (4'hE) strobes, release, bounce low 1 tick, then high 5 ticks. Expect no second strobe; scanning resumes.
6. With KEYPAD_AUTOREPEAT_EN defined (REPEAT_DELAY_MS=100, REPEAT_RATE_MS=50), hold "D" 300 clk. Expect strobes with key_code=4'hD at t0, t0+100, t0+150, t0+200, t0+250 clk.
